// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-rate timer: mod-(div+1) counter, bit_tick high on the last clock of each bit.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign bit_tick = (cnt_q == div);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else if (clear || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  uart_tx_state_e        state_q, state_n;
  logic                  tx_q, tx_n;
  logic [DATA_WIDTH-1:0] data_q, shift_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q, par_odd_q, two_stop_q;
  logic [IDX_W-1:0]      idx_q;

  logic accept, bit_tick, load, shift_en, idx_clr, idx_inc;
  logic last_data, last_stop, parity_bit;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
    .clk      (clk),
    .reset_b  (reset_b),
    .clear    (load),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  assign last_data  = (idx_q == IDX_W'(DATA_WIDTH - 1));
  assign last_stop  = (idx_q == IDX_W'(two_stop_q));
  assign parity_bit = par_odd_q ? ~^data_q : ^data_q;

  assign tx_done  = (state_q == STOP) && bit_tick && last_stop;
  assign tx_ready = (state_q == IDLE) || tx_done;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state_q;
    tx_n     = tx_q;
    load     = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;

    unique case (state_q)
      IDLE: tx_n = UART_IDLE_LVL;
      START: if (bit_tick) begin
        state_n = DATA;
        tx_n    = shift_q[0];
      end
      DATA: if (bit_tick) begin
        if (last_data) begin
          idx_clr = 1'b1;
          state_n = par_en_q ? PARITY : STOP;
          tx_n    = par_en_q ? parity_bit : UART_IDLE_LVL;
        end else begin
          idx_inc  = 1'b1;
          shift_en = 1'b1;
          tx_n     = shift_q[1];
        end
      end
      PARITY: if (bit_tick) begin
        idx_clr = 1'b1;
        state_n = STOP;
        tx_n    = UART_IDLE_LVL;
      end
      STOP: if (bit_tick) begin
        if (last_stop) state_n = IDLE;
        else           idx_inc = 1'b1;
        tx_n = UART_IDLE_LVL;
      end
      default: begin
        state_n = IDLE;
        tx_n    = UART_IDLE_LVL;
      end
    endcase

    // An accept overrides whatever the final stop clock chose, giving zero-gap frames.
    if (accept) begin
      state_n = START;
      tx_n    = UART_START_LVL;
      load    = 1'b1;
      idx_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_n;
      tx_q    <= tx_n;
    end
  end

  // Frame configuration is captured only on accept, so mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_q     <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (load) begin
      data_q     <= tx_data;
      shift_q    <= tx_data;
      div_q      <= baud_div;
      par_en_q   <= parity_en;
      par_odd_q  <= parity_odd;
      two_stop_q <= two_stop;
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Shared index: data bit number in DATA, stop bit number in STOP.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      idx_q <= '0;
    end else if (idx_clr) begin
      idx_q <= '0;
    end else if (idx_inc) begin
      idx_q <= idx_q + 1'b1;
    end
  end

endmodule : uart_tx_engine
